ili9341_spi_sink: RTL and testbench
===================================

# ili9341_spi_sink

Display-side receiver for the ILI9341 4-wire SPI link: the responder at the far end of the controller's write-only bus. It oversamples SCLK/MOSI/CS/DC with the system clock and assembles bytes. It decodes the command/parameter stream (CASET, PASET, RAMWR, SWRESET, SLPOUT, DISPON/OFF) and emits one RGB565 pixel-write strobe with its (x, y) coordinate per pixel. It sits beside ili9341_top in simulation benches and FPGA loopback builds, where it acts as the panel model that checks what the controller sends.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_sclk/spi_mosi/spi_cs_n/spi_dc (min 2)
- DEF_EC, 239, column end after reset/SWRESET
- DEF_EP, 319, page end after reset/SWRESET

Ports:
- clk  in  1  system clock; must be at least 4x the SCLK frequency
- rst  in  1  synchronous, active-high reset
- spi_sclk  in  1  SPI clock, mode 0 (idle low, sample on rising edge)
- spi_mosi  in  1  serial data, MSB first
- spi_cs_n  in  1  chip select, active low
- spi_dc  in  1  0 = command byte, 1 = data/parameter byte
- byte_valid  out  1  one-cycle strobe per received byte
- byte_data  out  8  received byte, held until the next strobe
- byte_is_data  out  1  DC value latched with the byte
- px_valid  out  1  one-cycle strobe per completed pixel
- px_x  out  9  column of the pixel being written
- px_y  out  9  page (row) of the pixel being written
- px_color  out  16  RGB565; high byte is the first received byte
- sleep_out  out  1  set by 0x11, cleared by 0x10, SWRESET and rst
- disp_on  out  1  set by 0x29, cleared by 0x28, SWRESET and rst
- proto_err  out  1  sticky; set on a parameter byte with no open command, or on a 5th+ CASET/PASET parameter

## Operation
- Front end: spi_sclk, spi_mosi, spi_cs_n and spi_dc each pass through a SYNC_STAGES flop chain. A rising edge is detected on the synchronized sclk by comparing it with a one-cycle-delayed copy.
- Bit counter (3 bits): shifts synchronized mosi in on each detected rising edge while synchronized cs_n = 0. It is cleared whenever synchronized cs_n = 1, so a partial byte is discarded when CS deasserts mid-byte. DC is latched on the 8th edge.
- Decoder FSM states: IDLE, CASET_P, PASET_P, RAMWR_D.
  - Any command byte (DC = 0) leaves the current state first, then dispatches on its value: 0x2A -> CASET_P; 0x2B -> PASET_P; 0x2C -> RAMWR_D; 0x01, 0x11, 0x10, 0x29, 0x28 -> IDLE with the side effect applied; any other value -> IDLE (it is ignored, and its parameters are swallowed without error).
  - CASET_P collects 4 parameter bytes as SC[15:8], SC[7:0], EC[15:8], EC[7:0]. Bits [8:0] of each word are kept. The window register updates only after the 4th byte, and the FSM stays in CASET_P. PASET_P works the same way for SP/EP.
  - RAMWR_D: on entry, x = SC, y = SP and the pixel byte-phase is cleared. The first data byte goes to the hi half, the second completes the pixel and raises px_valid with the current x, y.
    - Then: if x == EC, x <- SC and y advances, else x <- x + 1.
    - y advances as: if y == EP, y <- SP, else y <- y + 1.
  - A command byte arriving while a half-pixel is pending discards the half-pixel.
- SWRESET (0x01) restores SC = 0, EC = DEF_EC, SP = 0, EP = DEF_EP, and clears sleep_out and disp_on.
- Window arithmetic:
  - 9-bit, with no clamping against the panel size.
  - If SC > EC, x still wraps only on equality, so x increments mod 512 until it equals EC. The same rule applies to y. This matches the panel model; no error is flagged.
- CS deassertion does not close RAMWR. A stream may continue across CS pulses until a command byte arrives.
- rst in any state:
  - FSM goes to IDLE; bit counter, byte-phase and all strobes go to 0.
  - byte_data = 0, byte_is_data = 0, px_x = px_y = 0, px_color = 0.
  - SC/EC/SP/EP take their default values.
  - sleep_out = disp_on = proto_err = 0.

## Timing
- byte_valid rises exactly SYNC_STAGES+1 clk cycles after the clk edge that first samples the 8th SCLK rising edge at the pin. It is high for 1 cycle.
- px_valid rises 1 cycle after the byte_valid of the pixel's low byte. px_x, px_y and px_color are valid in that cycle and held until the next px_valid.
- Window registers and the FSM state update in the cycle after byte_valid, so a byte arriving back-to-back at 4 clk/bit is honoured.
- byte_valid and px_valid are never high in the same cycle.
- A 4-parameter CASET or PASET takes effect before the following RAMWR byte is decoded.

## Test plan
- Reset, then clock SCLK at clk/4 and send cmd 0x2C followed by data 0xF8,0x00 -> byte_valid fires 3 times; px_valid once with x=0, y=0, color=0xF800.
- CASET 0x00,0x0A,0x00,0x0B; PASET 0x00,0x14,0x00,0x15; RAMWR with 5 pixels -> coordinates (10,20),(11,20),(10,21),(11,21),(10,20). This checks both the x and y wrap.
- Send 5 bits, pulse CS high, then send byte 0x29 with DC=0 -> only one byte_valid, byte_data=0x29, and disp_on rises.
- RAMWR, one data byte 0x12, then cmd 0x2C, then 0xAB,0xCD -> a single px_valid with color 0xABCD at (SC,SP).
- Data byte 0x55 after reset with no command -> proto_err=1 and stays set. A following SWRESET does not clear it; only rst clears it.
- Assert rst in the middle of a RAMWR stream, then send 2 data bytes -> no px_valid, because the FSM is in IDLE, and proto_err=1.

Source files
------------

// File: rtl/ili9341_spi_sink.sv
// ILI9341 4-wire SPI receiver / panel model.
// Oversamples the SPI pins, assembles bytes, decodes the command stream and
// emits one RGB565 pixel strobe with its (x, y) coordinate per written pixel.
module ili9341_spi_sink #(
   parameter int SYNC_STAGES = 2,
   parameter int DEF_EC      = 239,
   parameter int DEF_EP      = 319
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sclk,
   input  logic        spi_mosi,
   input  logic        spi_cs_n,
   input  logic        spi_dc,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_is_data,
   output logic        px_valid,
   output logic [8:0]  px_x,
   output logic [8:0]  px_y,
   output logic [15:0] px_color,
   output logic        sleep_out,
   output logic        disp_on,
   output logic        proto_err
);

   typedef enum logic [1:0] {S_IDLE, S_CASET_P, S_PASET_P, S_RAMWR_D} state_t;

   localparam logic [8:0] L_DEF_EC = 9'(DEF_EC);
   localparam logic [8:0] L_DEF_EP = 9'(DEF_EP);

   // front end
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync, r_dc_sync;
   logic       r_sclk_d, r_sclk_d2, r_mosi_d, r_cs_d, r_dc_d;
   logic       w_rise;
   logic [2:0] r_bitcnt;
   logic [6:0] r_shift;
   logic       r_byte_valid, r_byte_is_data;
   logic [7:0] r_byte_data;

   // decoder
   state_t     r_state, w_state_nxt;
   logic       w_cmd, w_dat, w_known, w_in_win, w_param, w_err;
   logic       w_px_hi, w_px_fire, w_y_adv;
   logic [8:0] w_word, w_x_nxt, w_y_nxt;
   logic [2:0] r_pcnt;
   logic       r_p_hi, r_phase, r_swallow;
   logic [8:0] r_p_start, r_sc, r_ec, r_sp, r_ep, r_x, r_y;
   logic [7:0] r_color_hi;
   logic       r_px_valid, r_sleep, r_disp, r_proto_err;
   logic [8:0] r_px_x, r_px_y;
   logic [15:0] r_px_color;

   // Pin synchronizers plus one extra aligned stage used for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_dc_sync   <= '0;
         r_sclk_d    <= 1'b0;
         r_sclk_d2   <= 1'b0;
         r_mosi_d    <= 1'b0;
         r_cs_d      <= 1'b1;
         r_dc_d      <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], spi_dc};
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
         r_sclk_d2   <= r_sclk_d;
         r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
         r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
         r_dc_d      <= r_dc_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise = r_sclk_d & ~r_sclk_d2;

   // Shift in MSB-first bits; CS high discards any partial byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bitcnt       <= 3'd0;
         r_shift        <= 7'd0;
         r_byte_valid   <= 1'b0;
         r_byte_data    <= 8'd0;
         r_byte_is_data <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         if (r_cs_d) begin
            r_bitcnt <= 3'd0;
         end else if (w_rise) begin
            r_shift  <= {r_shift[5:0], r_mosi_d};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
               r_byte_valid   <= 1'b1;
               r_byte_data    <= {r_shift, r_mosi_d};
               r_byte_is_data <= r_dc_d;
            end
         end
      end
   end

   assign w_cmd  = r_byte_valid & ~r_byte_is_data;
   assign w_dat  = r_byte_valid & r_byte_is_data;
   assign w_word = {r_p_hi, r_byte_data};

   // Decoder state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: every command byte re-dispatches, data bytes never move the FSM.
   always_comb begin
      w_state_nxt = r_state;
      if (w_cmd) begin
         case (r_byte_data)
            8'h2A:   w_state_nxt = S_CASET_P;
            8'h2B:   w_state_nxt = S_PASET_P;
            8'h2C:   w_state_nxt = S_RAMWR_D;
            default: w_state_nxt = S_IDLE;
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Decode strobes for the datapath and next pixel coordinate.
   always_comb begin
      w_known = 1'b0;
      case (r_byte_data)
         8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C: w_known = 1'b1;
         default: w_known = 1'b0;
      endcase
      w_in_win  = (r_state == S_CASET_P) || (r_state == S_PASET_P);
      w_param   = w_dat & w_in_win & (r_pcnt != 3'd4);
      w_err     = w_dat & (((r_state == S_IDLE) & ~r_swallow) |
                           (w_in_win & (r_pcnt == 3'd4)));
      w_px_hi   = w_dat & (r_state == S_RAMWR_D) & ~r_phase;
      w_px_fire = w_dat & (r_state == S_RAMWR_D) & r_phase;
      // Wrap only on equality, so a reversed window runs mod 512.
      if (r_x == r_ec) begin
         w_x_nxt = r_sc;
         w_y_adv = 1'b1;
      end else begin
         w_x_nxt = r_x + 9'd1;
         w_y_adv = 1'b0;
      end
      if (w_y_adv) begin
         if (r_y == r_ep) begin
            w_y_nxt = r_sp;
         end else begin
            w_y_nxt = r_y + 9'd1;
         end
      end else begin
         w_y_nxt = r_y;
      end
   end

   // Window registers, side effects, pixel assembly and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt      <= 3'd0;
         r_p_hi      <= 1'b0;
         r_p_start   <= 9'd0;
         r_phase     <= 1'b0;
         r_swallow   <= 1'b0;
         r_sc        <= 9'd0;
         r_ec        <= L_DEF_EC;
         r_sp        <= 9'd0;
         r_ep        <= L_DEF_EP;
         r_x         <= 9'd0;
         r_y         <= 9'd0;
         r_color_hi  <= 8'd0;
         r_px_valid  <= 1'b0;
         r_px_x      <= 9'd0;
         r_px_y      <= 9'd0;
         r_px_color  <= 16'd0;
         r_sleep     <= 1'b0;
         r_disp      <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_px_valid <= 1'b0;
         if (w_cmd) begin
            r_pcnt    <= 3'd0;
            r_phase   <= 1'b0;
            r_swallow <= ~w_known;
            case (r_byte_data)
               8'h01: begin
                  r_sc    <= 9'd0;
                  r_ec    <= L_DEF_EC;
                  r_sp    <= 9'd0;
                  r_ep    <= L_DEF_EP;
                  r_sleep <= 1'b0;
                  r_disp  <= 1'b0;
               end
               8'h11:   r_sleep <= 1'b1;
               8'h10:   r_sleep <= 1'b0;
               8'h29:   r_disp  <= 1'b1;
               8'h28:   r_disp  <= 1'b0;
               8'h2C: begin
                  r_x <= r_sc;
                  r_y <= r_sp;
               end
               default: begin
               end
            endcase
         end
         if (w_param) begin
            r_pcnt <= r_pcnt + 3'd1;
            case (r_pcnt)
               3'd0: r_p_hi    <= r_byte_data[0];
               3'd1: r_p_start <= w_word;
               3'd2: r_p_hi    <= r_byte_data[0];
               3'd3: begin
                  if (r_state == S_CASET_P) begin
                     r_sc <= r_p_start;
                     r_ec <= w_word;
                  end else begin
                     r_sp <= r_p_start;
                     r_ep <= w_word;
                  end
               end
               default: begin
               end
            endcase
         end
         if (w_err) begin
            r_proto_err <= 1'b1;
         end
         if (w_px_hi) begin
            r_color_hi <= r_byte_data;
            r_phase    <= 1'b1;
         end
         if (w_px_fire) begin
            r_px_valid <= 1'b1;
            r_px_x     <= r_x;
            r_px_y     <= r_y;
            r_px_color <= {r_color_hi, r_byte_data};
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_phase    <= 1'b0;
         end
      end
   end

   assign byte_valid   = r_byte_valid;
   assign byte_data    = r_byte_data;
   assign byte_is_data = r_byte_is_data;
   assign px_valid     = r_px_valid;
   assign px_x         = r_px_x;
   assign px_y         = r_px_y;
   assign px_color     = r_px_color;
   assign sleep_out    = r_sleep;
   assign disp_on      = r_disp;
   assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_ili9341_spi_sink.sv
// Directed bench for ili9341_spi_sink: a byte-by-byte vector table plus
// hand-written sequences for CS aborts, sticky errors and mid-stream reset.
module tb_ili9341_spi_sink;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst, spi_sclk, spi_mosi, spi_cs_n, spi_dc;
   logic        byte_valid, byte_is_data, px_valid, sleep_out, disp_on, proto_err;
   logic [7:0]  byte_data;
   logic [8:0]  px_x, px_y;
   logic [15:0] px_color;

   ili9341_spi_sink #(.SYNC_STAGES(SYNC), .DEF_EC(239), .DEF_EP(319)) dut (
      .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n), .spi_dc(spi_dc), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_is_data(byte_is_data), .px_valid(px_valid),
      .px_x(px_x), .px_y(px_y), .px_color(px_color), .sleep_out(sleep_out),
      .disp_on(disp_on), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // event monitor, sampled on the falling edge
   int          bv_cnt = 0, px_cnt = 0, overlap = 0;
   logic [7:0]  m_b = 8'd0;
   logic        m_dc = 1'b0;
   logic [8:0]  m_x = 9'd0, m_y = 9'd0;
   logic [15:0] m_c = 16'd0;

   always @(negedge clk) begin
      if (byte_valid) begin
         bv_cnt = bv_cnt + 1;
         m_b    = byte_data;
         m_dc   = byte_is_data;
      end
      if (px_valid) begin
         px_cnt = px_cnt + 1;
         m_x    = px_x;
         m_y    = px_y;
         m_c    = px_color;
      end
      if (byte_valid && px_valid) overlap = overlap + 1;
   end

   typedef struct {
      logic        dc;
      logic [7:0]  b;
      logic        px;
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] col;
      logic        slp;
      logic        dsp;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic dc, input logic [7:0] b, input logic px,
                               input int x, input int y, input logic [15:0] col,
                               input logic slp, input logic dsp);
      vec_t v;
      v.dc = dc; v.b = b; v.px = px; v.x = 9'(x); v.y = 9'(y);
      v.col = col; v.slp = slp; v.dsp = dsp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      settle();
   endtask

   // One byte at clk/4; lat = cycles from the edge seeing the 8th SCLK rise to byte_valid.
   task automatic send_byte(input logic dc, input logic [7:0] b, output int lat);
      lat = 99;
      @(negedge clk);
      spi_cs_n = 1'b0;
      spi_dc   = dc;
      for (int i = 7; i >= 0; i--) begin
         spi_sclk = 1'b0;
         spi_mosi = b[i];
         repeat (2) @(negedge clk);
         spi_sclk = 1'b1;
         if (i == 0) begin
            for (int k = 1; k <= 10; k++) begin
               @(posedge clk);
               #1;
               if (byte_valid) begin
                  lat = k - 1;
                  break;
               end
            end
            @(negedge clk);
         end else begin
            repeat (2) @(negedge clk);
         end
      end
      spi_sclk = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, b0, p0;

      // {dc, byte, px?, x, y, color, sleep, disp}
      tv.push_back(mk(1'b0, 8'h2C, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hF8, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h00, 1'b1, 0, 0, 16'hF800, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 8'h2A, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h00, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h0A, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h00, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h0B, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 8'h2B, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h00, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h14, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h00, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h15, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 8'h2C, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hA0, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h01, 1'b1, 10, 20, 16'hA001, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hA0, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h02, 1'b1, 11, 20, 16'hA002, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hA0, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h03, 1'b1, 10, 21, 16'hA003, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hA0, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h04, 1'b1, 11, 21, 16'hA004, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hA0, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h05, 1'b1, 10, 20, 16'hA005, 1'b0, 1'b0));
      // half pixel discarded by a new RAMWR
      tv.push_back(mk(1'b0, 8'h2C, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h12, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 8'h2C, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hAB, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'hCD, 1'b1, 10, 20, 16'hABCD, 1'b0, 1'b0));
      // power / display state and SWRESET
      tv.push_back(mk(1'b0, 8'h11, 1'b0, 0, 0, 16'h0, 1'b1, 1'b0));
      tv.push_back(mk(1'b0, 8'h29, 1'b0, 0, 0, 16'h0, 1'b1, 1'b1));
      tv.push_back(mk(1'b0, 8'h28, 1'b0, 0, 0, 16'h0, 1'b1, 1'b0));
      tv.push_back(mk(1'b0, 8'h29, 1'b0, 0, 0, 16'h0, 1'b1, 1'b1));
      tv.push_back(mk(1'b0, 8'h01, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b0, 8'h2C, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h00, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h01, 1'b1, 0, 0, 16'h0001, 1'b0, 1'b0));
      // unknown command swallows its parameters without error
      tv.push_back(mk(1'b0, 8'hB1, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h05, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 8'h06, 1'b0, 0, 0, 16'h0, 1'b0, 1'b0));

      rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
      do_reset();

      // reset state
      chk("rst_byte_valid", 32'(byte_valid), 32'd0);
      chk("rst_px_valid", 32'(px_valid), 32'd0);
      chk("rst_byte_data", 32'(byte_data), 32'd0);
      chk("rst_byte_is_data", 32'(byte_is_data), 32'd0);
      chk("rst_px_x", 32'(px_x), 32'd0);
      chk("rst_px_y", 32'(px_y), 32'd0);
      chk("rst_px_color", 32'(px_color), 32'd0);
      chk("rst_sleep", 32'(sleep_out), 32'd0);
      chk("rst_disp", 32'(disp_on), 32'd0);
      chk("rst_err", 32'(proto_err), 32'd0);

      // table
      for (int i = 0; i < tv.size(); i++) begin
         b0 = bv_cnt;
         p0 = px_cnt;
         send_byte(tv[i].dc, tv[i].b, lat);
         settle();
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(SYNC + 1));
         chk($sformatf("v%0d_byte_cnt", i), 32'(bv_cnt - b0), 32'd1);
         chk($sformatf("v%0d_byte_data", i), 32'(m_b), 32'(tv[i].b));
         chk($sformatf("v%0d_byte_dc", i), 32'(m_dc), 32'(tv[i].dc));
         chk($sformatf("v%0d_px_cnt", i), 32'(px_cnt - p0), 32'(tv[i].px));
         if (tv[i].px) begin
            chk($sformatf("v%0d_px_x", i), 32'(m_x), 32'(tv[i].x));
            chk($sformatf("v%0d_px_y", i), 32'(m_y), 32'(tv[i].y));
            chk($sformatf("v%0d_px_color", i), 32'(m_c), 32'(tv[i].col));
         end
         chk($sformatf("v%0d_sleep", i), 32'(sleep_out), 32'(tv[i].slp));
         chk($sformatf("v%0d_disp", i), 32'(disp_on), 32'(tv[i].dsp));
         chk($sformatf("v%0d_err", i), 32'(proto_err), 32'd0);
      end

      // partial byte aborted by CS, then DISPON
      do_reset();
      b0 = bv_cnt;
      @(negedge clk);
      spi_cs_n = 1'b0;
      spi_dc   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         spi_sclk = 1'b0;
         spi_mosi = ~spi_mosi;
         repeat (2) @(negedge clk);
         spi_sclk = 1'b1;
         repeat (2) @(negedge clk);
      end
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
      send_byte(1'b0, 8'h29, lat);
      settle();
      chk("cs_abort_byte_cnt", 32'(bv_cnt - b0), 32'd1);
      chk("cs_abort_byte_data", 32'(m_b), 32'h29);
      chk("cs_abort_byte_dc", 32'(m_dc), 32'd0);
      chk("cs_abort_disp_on", 32'(disp_on), 32'd1);

      // sticky proto_err: survives SWRESET, cleared only by rst
      do_reset();
      send_byte(1'b1, 8'h55, lat);
      settle();
      chk("orphan_data_err", 32'(proto_err), 32'd1);
      send_byte(1'b0, 8'h01, lat);
      settle();
      chk("swreset_keeps_err", 32'(proto_err), 32'd1);
      do_reset();
      chk("rst_clears_err", 32'(proto_err), 32'd0);

      // 5th CASET parameter is an error
      send_byte(1'b0, 8'h2A, lat);
      for (int i = 0; i < 4; i++) send_byte(1'b1, 8'h00, lat);
      settle();
      chk("caset4_no_err", 32'(proto_err), 32'd0);
      send_byte(1'b1, 8'h00, lat);
      settle();
      chk("caset5_err", 32'(proto_err), 32'd1);

      // rst in the middle of a RAMWR stream
      do_reset();
      send_byte(1'b0, 8'h2C, lat);
      send_byte(1'b1, 8'hF8, lat);
      do_reset();
      chk("mid_rst_byte_data", 32'(byte_data), 32'd0);
      p0 = px_cnt;
      send_byte(1'b1, 8'h11, lat);
      send_byte(1'b1, 8'h22, lat);
      settle();
      chk("mid_rst_no_px", 32'(px_cnt - p0), 32'd0);
      chk("mid_rst_err", 32'(proto_err), 32'd1);

      chk("no_strobe_overlap", 32'(overlap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
